mem_arbiter: RTL and testbench

- Shares one backing memory (memory_d-style: ren/wen strobes, memsig completion) between the instruction-side cache controller and the data-side cache controller.
- Selects one requester, latches its command, and holds the memory strobes until completion or timeout.
- Returns a one-cycle acknowledge plus read data to the owner.
- Sits between both cache controllers and the single memory model in the RISC-V top level.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around mem_arbiter.
// master = arbiter view; slave = view of the caches and memory model around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_address;
    logic              i_ack;
    logic [DATA_W-1:0] i_dataout;

    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_datain;
    logic [3:0]        d_byte_select;
    logic              d_ack;
    logic [DATA_W-1:0] d_dataout;

    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_datain;
    logic [3:0]        mem_byte_selector;
    logic [DATA_W-1:0] mem_dataout;
    logic              mem_memsig;

    logic              err;
    logic              busy;

    modport master (
        input  i_req, i_address, d_ren, d_wen, d_address, d_datain, d_byte_select,
               mem_dataout, mem_memsig,
        output i_ack, i_dataout, d_ack, d_dataout, mem_ren, mem_wen, mem_address,
               mem_datain, mem_byte_selector, err, busy
    );

    modport slave (
        output i_req, i_address, d_ren, d_wen, d_address, d_datain, d_byte_select,
               mem_dataout, mem_memsig,
        input  i_ack, i_dataout, d_ack, d_dataout, mem_ren, mem_wen, mem_address,
               mem_datain, mem_byte_selector, err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory between the I-side and D-side cache controllers:
// arbitrate in IDLE, hold latched strobes until memsig or timeout, then ack once.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RR_MODE    = 0,
    parameter int STARVE_LIM = 4,
    parameter int TIMEOUT    = 64
) (
    input logic           clk,
    input logic           reset,
    mem_arbiter_if.master bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int SW = $clog2(STARVE_LIM) + 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [3:0]        lat_be;
    logic              lat_wr;
    logic              owner_d;
    logic              err_flag;
    logic [TW-1:0]     tcnt;
    logic [SW-1:0]     starve_cnt;
    logic              last_d;
    logic [DATA_W-1:0] i_data_q;
    logic [DATA_W-1:0] d_data_q;

    logic d_req;
    logic pick_d;
    logic in_grant;

    always_comb begin
        d_req  = bus.d_ren | bus.d_wen;
        pick_d = 1'b0;
        if (d_req && !bus.i_req) begin
            pick_d = 1'b1;
        end else if (d_req && bus.i_req) begin
            // Tie: round-robin favours whoever did not win last; otherwise D wins unless I is starved
            if (RR_MODE != 0)
                pick_d = !last_d;
            else
                pick_d = (starve_cnt != SW'(STARVE_LIM));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_be     <= '0;
            lat_wr     <= 1'b0;
            owner_d    <= 1'b0;
            err_flag   <= 1'b0;
            tcnt       <= '0;
            starve_cnt <= '0;
            last_d     <= 1'b0;
            i_data_q   <= '0;
            d_data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_req || d_req) begin
                        owner_d  <= pick_d;
                        last_d   <= pick_d;
                        err_flag <= 1'b0;
                        tcnt     <= '0;
                        if (pick_d) begin
                            lat_addr <= bus.d_address;
                            lat_data <= bus.d_datain;
                            lat_be   <= bus.d_byte_select;
                            lat_wr   <= bus.d_wen;
                            state    <= GRANT_D;
                            if (bus.i_req && starve_cnt != SW'(STARVE_LIM))
                                starve_cnt <= starve_cnt + 1'b1;
                        end else begin
                            lat_addr   <= bus.i_address;
                            lat_data   <= '0;
                            lat_be     <= '1;
                            lat_wr     <= 1'b0;
                            state      <= GRANT_I;
                            starve_cnt <= '0;
                        end
                    end
                end
                GRANT_I, GRANT_D: begin
                    tcnt <= tcnt + 1'b1;
                    if (bus.mem_memsig) begin
                        if (!lat_wr) begin
                            if (owner_d)
                                d_data_q <= bus.mem_dataout;
                            else
                                i_data_q <= bus.mem_dataout;
                        end
                        state <= RESP;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_flag <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once
    assign in_grant              = (state == GRANT_I) || (state == GRANT_D);
    assign bus.mem_ren           = in_grant && !lat_wr;
    assign bus.mem_wen           = in_grant && lat_wr;
    assign bus.mem_address       = lat_addr;
    assign bus.mem_datain        = lat_data;
    assign bus.mem_byte_selector = lat_be;

    assign bus.i_ack     = (state == RESP) && !owner_d;
    assign bus.d_ack     = (state == RESP) && owner_d;
    assign bus.err       = (state == RESP) && err_flag;
    assign bus.busy      = (state != IDLE);
    assign bus.i_dataout = i_data_q;
    assign bus.d_dataout = d_data_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter: the bench plays both caches and
// the memory, predicting winner, strobe window, ack, err and returned data per transaction.
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
    localparam int TO  = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rif ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .STARVE_LIM(LIM), .TIMEOUT(TO))
        dut (.clk(clk), .reset(reset), .bus(bif));

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .STARVE_LIM(LIM), .TIMEOUT(TO))
        dut_rr (.clk(clk), .reset(reset), .bus(rif));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Pending requests as the caches see them (held until acked)
    logic        i_pend, d_pend, d_wr_p, d_both_p;
    logic [31:0] i_addr_p, d_addr_p, d_data_p;
    logic [3:0]  d_be_p;
    logic [31:0] exp_i_data, exp_d_data;
    int          starve;

    task automatic drive_reqs();
        bif.i_req         = i_pend;
        bif.i_address     = i_addr_p;
        bif.d_wen         = d_pend && d_wr_p;
        bif.d_ren         = d_pend && (!d_wr_p || d_both_p);
        bif.d_address     = d_addr_p;
        bif.d_datain      = d_data_p;
        bif.d_byte_select = d_be_p;
    endtask

    task automatic new_reqs(input bit both);
        if (!i_pend && (both || $urandom_range(0, 1) == 1)) begin
            i_pend   = 1'b1;
            i_addr_p = $urandom;
        end
        if (!d_pend && (both || $urandom_range(0, 1) == 1 || !i_pend)) begin
            d_pend   = 1'b1;
            d_wr_p   = 1'($urandom_range(0, 1));
            d_both_p = d_wr_p && ($urandom_range(0, 1) == 1);
            d_addr_p = $urandom;
            d_data_p = $urandom;
            d_be_p   = 4'($urandom_range(1, 15));
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, bif.busy, 0);
        check_eq({tag, "_ren"}, bif.mem_ren, 0);
        check_eq({tag, "_wen"}, bif.mem_wen, 0);
        check_eq({tag, "_iack"}, bif.i_ack, 0);
        check_eq({tag, "_dack"}, bif.d_ack, 0);
        check_eq({tag, "_idata"}, bif.i_dataout, exp_i_data);
        check_eq({tag, "_ddata"}, bif.d_dataout, exp_d_data);
    endtask

    // One transaction, entered at the negedge of an IDLE cycle
    task automatic run_txn(input bit both);
        bit          win_d, wr, timed_out;
        int          k, last;
        logic [31:0] rdata, exp_addr;
        logic [3:0]  exp_be;
        @(negedge clk);
        new_reqs(both);
        drive_reqs();
        win_d = (i_pend && d_pend) ? (starve != LIM) : d_pend;
        if (!win_d) starve = 0;
        else if (i_pend) starve = (starve < LIM) ? starve + 1 : LIM;
        wr        = win_d && d_wr_p;
        exp_addr  = win_d ? d_addr_p : i_addr_p;
        exp_be    = win_d ? d_be_p : 4'hF;
        k         = $urandom_range(1, TO + 2);
        timed_out = (k > TO);
        last      = timed_out ? TO : k;
        rdata     = $urandom;
        @(posedge clk); #1;
        for (int j = 1; j <= last; j++) begin
            check_eq("grant_ren", bif.mem_ren, !wr);
            check_eq("grant_wen", bif.mem_wen, wr);
            check_eq("grant_addr", bif.mem_address, exp_addr);
            check_eq("grant_be", bif.mem_byte_selector, exp_be);
            if (wr) check_eq("grant_wdata", bif.mem_datain, d_data_p);
            check_eq("grant_busy", bif.busy, 1);
            check_eq("grant_acks", {bif.i_ack, bif.d_ack, bif.err}, 0);
            @(negedge clk);
            bif.i_address     = $urandom;
            bif.d_address     = $urandom;
            bif.d_datain      = $urandom;
            bif.d_byte_select = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                if (win_d) begin bif.d_ren = 1'b0; bif.d_wen = 1'b0; end
                else bif.i_req = 1'b0;
            end
            bif.mem_memsig  = (!timed_out && j == k);
            bif.mem_dataout = (!timed_out && j == k) ? rdata : $urandom;
            @(posedge clk); #1;
        end
        if (!timed_out && !wr) begin
            if (win_d) exp_d_data = rdata;
            else exp_i_data = rdata;
        end
        check_eq("resp_iack", bif.i_ack, !win_d);
        check_eq("resp_dack", bif.d_ack, win_d);
        check_eq("resp_err", bif.err, timed_out);
        check_eq("resp_idata", bif.i_dataout, exp_i_data);
        check_eq("resp_ddata", bif.d_dataout, exp_d_data);
        check_eq("resp_strobes", {bif.mem_ren, bif.mem_wen}, 0);
        check_eq("resp_busy", bif.busy, 1);
        if (win_d) d_pend = 1'b0;
        else i_pend = 1'b0;
        @(negedge clk);
        bif.mem_memsig  = 1'($urandom_range(0, 1));
        bif.mem_dataout = $urandom;
        drive_reqs();
        @(posedge clk); #1;
        check_quiet("idle");
    endtask

    int rr_acks;
    bit rr_exp_d;

    initial begin
        i_pend = 0; d_pend = 0; d_wr_p = 0; d_both_p = 0;
        i_addr_p = 0; d_addr_p = 0; d_data_p = 0; d_be_p = 0;
        exp_i_data = 0; exp_d_data = 0; starve = 0;
        drive_reqs();
        bif.mem_memsig = 0; bif.mem_dataout = 0;
        rif.i_req = 0; rif.i_address = 32'h200; rif.d_ren = 0; rif.d_wen = 0;
        rif.d_address = 32'h300; rif.d_datain = 0; rif.d_byte_select = 4'hF;
        rif.mem_memsig = 0; rif.mem_dataout = 32'h1234;

        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        check_eq("reset_addr", bif.mem_address, 0);
        check_eq("reset_be", bif.mem_byte_selector, 0);
        check_eq("reset_err", bif.err, 0);
        @(negedge clk);
        reset = 1'b1;

        // Round-robin instance: both held, memory always ready -> D, I, D, I ...
        rif.i_req = 1; rif.d_ren = 1; rif.mem_memsig = 1;
        rr_acks  = 0;
        rr_exp_d = 1'b1;
        for (int c = 0; c < 40 && rr_acks < 8; c++) begin
            @(posedge clk); #1;
            if (rif.i_ack || rif.d_ack) begin
                check_eq("rr_dack", rif.d_ack, rr_exp_d);
                check_eq("rr_iack", rif.i_ack, !rr_exp_d);
                rr_exp_d = !rr_exp_d;
                rr_acks++;
            end
        end
        check_eq("rr_ack_count", rr_acks, 8);
        rif.i_req = 0; rif.d_ren = 0; rif.mem_memsig = 0;

        repeat (50) run_txn(1'b0);
        repeat (14) run_txn(1'b1);
        repeat (20) run_txn(1'b0);

        // Reset during the second grant cycle of an I read
        @(negedge clk);
        d_pend = 0; i_pend = 1; i_addr_p = 32'h100;
        drive_reqs();
        @(posedge clk); #1;
        check_eq("rst_g1_ren", bif.mem_ren, 1);
        @(negedge clk);
        bif.mem_memsig = 0;
        @(posedge clk); #1;
        check_eq("rst_g2_ren", bif.mem_ren, 1);
        @(negedge clk);
        reset = 1'b0;
        bif.i_req = 0;
        #1;
        exp_i_data = 0; exp_d_data = 0; starve = 0;
        check_quiet("rst_async");
        check_eq("rst_async_addr", bif.mem_address, 0);
        @(posedge clk); #1;
        check_quiet("rst_held");
        @(negedge clk);
        reset = 1'b1;
        repeat (6) run_txn(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
